kbd_cmd_scheduler: RTL and testbench

Turns the PS/2 make-code stream into game commands and feeds them to `game_logic` at the game-tick rate. It sits between `ps2_kbd_adapter` and `game_logic`, replacing the per-key toggle/synchroniser scheme. All of its logic runs on CLOCK_50, and it drives a tick clock-enable instead of a divided clock. It buffers keystrokes in a small FIFO, issues at most one command per tick over a valid/ready handshake, and owns the title-screen dismissal flag.

---
 rtl/kbd_pkg.sv | 56 +++++
 rtl/cmd_fifo.sv | 58 +++++
 rtl/kbd_cmd_scheduler.sv | 132 +++++++++++++
 tb/tb_kbd_cmd_scheduler.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/kbd_pkg.sv
// Shared types for the keyboard command scheduler: command codes,
// PS/2 make-code constants, issue FSM states and the key decoder.
package kbd_pkg;

    typedef enum logic [3:0] {
        CMD_NONE   = 4'd0,
        CMD_LEFT   = 4'd1,
        CMD_RIGHT  = 4'd2,
        CMD_UP     = 4'd3,
        CMD_DOWN   = 4'd4,
        CMD_PLACE  = 4'd5,
        CMD_ROTATE = 4'd6,
        CMD_SEL1   = 4'd7,
        CMD_SEL2   = 4'd8,
        CMD_SEL3   = 4'd9
    } cmd_t;

    localparam logic [7:0] SC_LEFT_A  = 8'h6B;
    localparam logic [7:0] SC_LEFT_B  = 8'h1C;
    localparam logic [7:0] SC_RIGHT_A = 8'h74;
    localparam logic [7:0] SC_RIGHT_B = 8'h23;
    localparam logic [7:0] SC_UP_A    = 8'h75;
    localparam logic [7:0] SC_UP_B    = 8'h1D;
    localparam logic [7:0] SC_DOWN_A  = 8'h72;
    localparam logic [7:0] SC_DOWN_B  = 8'h1B;
    localparam logic [7:0] SC_PLACE   = 8'h29;
    localparam logic [7:0] SC_ROTATE  = 8'h2D;
    localparam logic [7:0] SC_SEL1    = 8'h16;
    localparam logic [7:0] SC_SEL2    = 8'h1E;
    localparam logic [7:0] SC_SEL3    = 8'h26;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_HOLD
    } issue_state_t;

    // Prefix bytes (E0, F0) and every other code map to CMD_NONE.
    function automatic cmd_t decode_scan(input logic [7:0] sc);
        cmd_t c;
        case (sc)
            SC_LEFT_A,  SC_LEFT_B:  c = CMD_LEFT;
            SC_RIGHT_A, SC_RIGHT_B: c = CMD_RIGHT;
            SC_UP_A,    SC_UP_B:    c = CMD_UP;
            SC_DOWN_A,  SC_DOWN_B:  c = CMD_DOWN;
            SC_PLACE:               c = CMD_PLACE;
            SC_ROTATE:              c = CMD_ROTATE;
            SC_SEL1:                c = CMD_SEL1;
            SC_SEL2:                c = CMD_SEL2;
            SC_SEL3:                c = CMD_SEL3;
            default:                c = CMD_NONE;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous command FIFO; DEPTH must be a power of two so the
// pointers wrap naturally. Push into a full FIFO succeeds only with a pop.
module cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 4
) (
    input  logic                     CLOCK_50,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (level == FULL_LVL);
    assign empty   = (level == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    // Storage write; contents need no reset since level gates reads.
    always_ff @(posedge CLOCK_50) begin
        if (do_push)
            mem[wr_ptr] <= din;
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/kbd_cmd_scheduler.sv
// PS/2 make codes -> queued game commands, one per tick over valid/ready.
// Optional KBD_DROP_CNT_EN adds a saturating drop_count output.
module kbd_cmd_scheduler
    import kbd_pkg::*;
#(
    parameter int TICK_DIV   = 1_000_000,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          CLOCK_50,
    input  logic                          reset,
    input  logic [7:0]                    scan_code,
    input  logic                          make_pulse,
    output logic                          tick,
    output logic                          cmd_valid,
    output logic [3:0]                    cmd_code,
    input  logic                          cmd_ready,
    output logic                          show_title,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
`ifdef KBD_DROP_CNT_EN
    ,
    output logic [7:0]                    drop_count
`endif
);

    localparam int CW = $clog2(TICK_DIV);
    localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);

    cmd_t         key_cmd;
    logic         push_req;
    logic         push_ok;
    logic         pop;
    logic         fifo_full;
    logic         fifo_empty;
    logic [3:0]   fifo_dout;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;
    issue_state_t state;
    issue_state_t state_next;

    assign key_cmd  = decode_scan(scan_code);
    assign push_req = make_pulse && !show_title && (key_cmd != CMD_NONE);
    assign push_ok  = push_req && (!fifo_full || pop);

    cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (4)
    ) u_fifo (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .push     (push_ok),
        .pop      (pop),
        .din      (key_cmd),
        .dout     (fifo_dout),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .level    (fifo_level)
    );

    // First keystroke after reset only dismisses the title screen.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset)
            show_title <= 1'b1;
        else if (make_pulse)
            show_title <= 1'b0;
    end

    // Next tick-counter value, wrapping at TICK_DIV-1.
    always_comb begin
        cnt_next = cnt + 1'b1;
        if (cnt == CNT_LAST)
            cnt_next = '0;
    end

    // Tick counter; tick is registered and tracks cnt == TICK_DIV-1.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else begin
            cnt  <= cnt_next;
            tick <= (cnt_next == CNT_LAST);
        end
    end

    // Issue FSM next state; a pop happens only on an IDLE tick.
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (tick && !fifo_empty && !show_title) begin
                    pop        = 1'b1;
                    state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (cmd_ready)
                    state_next = ST_HOLD;
            end
            ST_HOLD: begin
                if (tick)
                    state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // FSM state plus registered valid and command outputs.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            cmd_valid <= 1'b0;
            cmd_code  <= 4'd0;
        end else begin
            state     <= state_next;
            cmd_valid <= (state_next == ST_ISSUE);
            if (pop)
                cmd_code <= fifo_dout;
        end
    end

`ifdef KBD_DROP_CNT_EN
    // Count rejected pushes, saturating at 255.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset)
            drop_count <= 8'd0;
        else if (push_req && !push_ok && drop_count != 8'hFF)
            drop_count <= drop_count + 8'd1;
    end
`endif

endmodule

// File: tb/tb_kbd_cmd_scheduler.sv
// Directed bench for kbd_cmd_scheduler with TICK_DIV=4, FIFO_DEPTH=4.
// Window Wn = 1 time unit after the n-th rising edge following reset release.
module tb_kbd_cmd_scheduler;

    localparam int TD = 4;
    localparam int FD = 4;

    logic       CLOCK_50;
    logic       reset;
    logic [7:0] scan_code;
    logic       make_pulse;
    logic       tick;
    logic       cmd_valid;
    logic [3:0] cmd_code;
    logic       cmd_ready;
    logic       show_title;
    logic [2:0] fifo_level;
`ifdef KBD_DROP_CNT_EN
    logic [7:0] drop_count;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    kbd_cmd_scheduler #(
        .TICK_DIV   (TD),
        .FIFO_DEPTH (FD)
    ) dut (
        .CLOCK_50   (CLOCK_50),
        .reset      (reset),
        .scan_code  (scan_code),
        .make_pulse (make_pulse),
        .tick       (tick),
        .cmd_valid  (cmd_valid),
        .cmd_code   (cmd_code),
        .cmd_ready  (cmd_ready),
        .show_title (show_title),
        .fifo_level (fifo_level)
`ifdef KBD_DROP_CNT_EN
        ,
        .drop_count (drop_count)
`endif
    );

    initial CLOCK_50 = 1'b0;
    always #10 CLOCK_50 = ~CLOCK_50;

    task automatic step();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic stepn(input int n);
        repeat (n) step();
    endtask

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic expect_idle(input int n);
        repeat (n) begin
            step();
            chk("idle_valid", {7'd0, cmd_valid}, 8'd0);
        end
    endtask

    task automatic send(input logic [7:0] sc);
        make_pulse = 1'b1;
        scan_code  = sc;
        step();
        make_pulse = 1'b0;
    endtask

    task automatic wait_valid(input logic [3:0] exp, input string tag);
        int k = 0;
        do begin
            step();
            k++;
        end while (cmd_valid !== 1'b1 && k < 40);
        chk({tag, "_valid"}, {7'd0, cmd_valid}, 8'd1);
        chk({tag, "_code"}, {4'd0, cmd_code}, {4'd0, exp});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] fill [6];
        fill[0] = 8'h6B; fill[1] = 8'h74; fill[2] = 8'h75;
        fill[3] = 8'h72; fill[4] = 8'h29; fill[5] = 8'h2D;

        reset = 1'b1; make_pulse = 1'b0;
        scan_code = 8'h00; cmd_ready = 1'b0;
        stepn(3);
        chk("rst_title", {7'd0, show_title}, 8'd1);
        chk("rst_level", {5'd0, fifo_level}, 8'd0);
        chk("rst_valid", {7'd0, cmd_valid}, 8'd0);
        chk("rst_code",  {4'd0, cmd_code}, 8'd0);
        chk("rst_tick",  {7'd0, tick}, 8'd0);
`ifdef KBD_DROP_CNT_EN
        chk("rst_drop", drop_count, 8'd0);
`endif

        // Title dismissal: unmapped 5A clears the flag, is not queued.
        reset = 1'b0;
        make_pulse = 1'b1; scan_code = 8'h5A;
        step();                                   // W1
        chk("title_clr",   {7'd0, show_title}, 8'd0);
        chk("title_level", {5'd0, fifo_level}, 8'd0);
        chk("title_tick",  {7'd0, tick}, 8'd0);
        scan_code = 8'h29;
        step();                                   // W2
        make_pulse = 1'b0;
        chk("place_level", {5'd0, fifo_level}, 8'd1);
        chk("place_nvalid", {7'd0, cmd_valid}, 8'd0);
        step();                                   // W3
        chk("tick_first", {7'd0, tick}, 8'd1);
        chk("pre_issue",  {7'd0, cmd_valid}, 8'd0);
        step();                                   // W4
        chk("place_valid", {7'd0, cmd_valid}, 8'd1);
        chk("place_code",  {4'd0, cmd_code}, 8'd5);
        chk("place_pop",   {5'd0, fifo_level}, 8'd0);
        chk("tick_low",    {7'd0, tick}, 8'd0);
        cmd_ready = 1'b1;
        step();                                   // W5
        cmd_ready = 1'b0;
        chk("place_drop_v", {7'd0, cmd_valid}, 8'd0);

        // Issue/handshake with ready held high.
        send(8'h6B);                              // W6
        chk("hs_lvl1", {5'd0, fifo_level}, 8'd1);
        send(8'h74);                              // W7
        chk("hs_lvl2", {5'd0, fifo_level}, 8'd2);
        chk("hs_tick7", {7'd0, tick}, 8'd1);
        cmd_ready = 1'b1;
        step();                                   // W8
        chk("hold_tick_noissue", {7'd0, cmd_valid}, 8'd0);
        chk("hs_lvl_keep", {5'd0, fifo_level}, 8'd2);
        expect_idle(3);                           // W9..W11
        chk("hs_tick11", {7'd0, tick}, 8'd1);
        step();                                   // W12
        chk("hs1_valid", {7'd0, cmd_valid}, 8'd1);
        chk("hs1_code",  {4'd0, cmd_code}, 8'd1);
        chk("hs1_level", {5'd0, fifo_level}, 8'd1);
        expect_idle(7);                           // W13..W19
        step();                                   // W20
        chk("hs2_valid", {7'd0, cmd_valid}, 8'd1);
        chk("hs2_code",  {4'd0, cmd_code}, 8'd2);
        chk("hs2_level", {5'd0, fifo_level}, 8'd0);
        step();                                   // W21
        chk("hs2_one_cycle", {7'd0, cmd_valid}, 8'd0);
        cmd_ready = 1'b0;

        // Backpressure: UP held for 10 ticks, PLACE waits behind it.
        send(8'h1D);                              // W22
        send(8'h29);                              // W23
        chk("bp_level2", {5'd0, fifo_level}, 8'd2);
        step();                                   // W24
        stepn(3);                                 // W27
        step();                                   // W28
        chk("bp_valid", {7'd0, cmd_valid}, 8'd1);
        chk("bp_code",  {4'd0, cmd_code}, 8'd3);
        for (int i = 0; i < 10 * TD; i++) begin
            step();
            chk("bp_hold", {2'd0, cmd_valid, cmd_code, fifo_level[0]},
                {2'd0, 1'b1, 4'd3, 1'b1});
        end                                       // W68
        cmd_ready = 1'b1;
        step();                                   // W69
        cmd_ready = 1'b0;
        chk("bp_release", {7'd0, cmd_valid}, 8'd0);
        expect_idle(6);                           // W70..W75
        step();                                   // W76
        chk("bp_next_valid", {7'd0, cmd_valid}, 8'd1);
        chk("bp_next_code",  {4'd0, cmd_code}, 8'd5);
        cmd_ready = 1'b1;
        step();                                   // W77
        cmd_ready = 1'b0;

        // Full: six pushes, last two dropped.
        for (int i = 0; i < 6; i++) send(fill[i]); // W83
        chk("full_level", {5'd0, fifo_level}, 8'd4);
`ifdef KBD_DROP_CNT_EN
        chk("full_drop", drop_count, 8'd2);
`endif
        step();                                   // W84
        chk("full_q0_valid", {7'd0, cmd_valid}, 8'd1);
        chk("full_q0_code",  {4'd0, cmd_code}, 8'd1);
        chk("full_lvl3", {5'd0, fifo_level}, 8'd3);
        send(8'h16);                              // W85
        chk("refill_lvl4", {5'd0, fifo_level}, 8'd4);
        cmd_ready = 1'b1;
        step();                                   // W86
        cmd_ready = 1'b0;
        stepn(5);                                 // W91
        chk("pp_tick", {7'd0, tick}, 8'd1);
        chk("pp_pre_lvl", {5'd0, fifo_level}, 8'd4);

        // Push and pop on the same edge with the FIFO full.
        send(8'h1E);                              // W92
        chk("pp_valid", {7'd0, cmd_valid}, 8'd1);
        chk("pp_code",  {4'd0, cmd_code}, 8'd2);
        chk("pp_level", {5'd0, fifo_level}, 8'd4);
`ifdef KBD_DROP_CNT_EN
        chk("pp_nodrop", drop_count, 8'd2);
`endif
        cmd_ready = 1'b1;
        wait_valid(4'd3, "drain0");
        wait_valid(4'd4, "drain1");
        wait_valid(4'd7, "drain2");
        wait_valid(4'd8, "drain3");
        step();
        chk("drain_empty", {5'd0, fifo_level}, 8'd0);
        cmd_ready = 1'b0;

        // Reset while a command is presented.
        send(8'h26);
        wait_valid(4'd9, "sel3");
        reset = 1'b1;
        step();
        chk("mid_valid", {7'd0, cmd_valid}, 8'd0);
        chk("mid_level", {5'd0, fifo_level}, 8'd0);
        chk("mid_title", {7'd0, show_title}, 8'd1);
        chk("mid_tick",  {7'd0, tick}, 8'd0);
        chk("mid_code",  {4'd0, cmd_code}, 8'd0);
`ifdef KBD_DROP_CNT_EN
        chk("mid_drop", drop_count, 8'd0);
`endif

        // Mapped key after reset only clears title; prefixes ignored.
        reset = 1'b0;
        send(8'h6B);                              // R+1
        chk("r_title", {7'd0, show_title}, 8'd0);
        chk("r_lvl0",  {5'd0, fifo_level}, 8'd0);
        send(8'hE0);                              // R+2
        chk("e0_level", {5'd0, fifo_level}, 8'd0);
        send(8'hF0);                              // R+3
        chk("f0_level", {5'd0, fifo_level}, 8'd0);
        chk("r_tick", {7'd0, tick}, 8'd1);
        send(8'h1C);                              // R+4
        chk("alt_level", {5'd0, fifo_level}, 8'd1);
        wait_valid(4'd1, "alt_left");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
